// File: rtl/dequant_pkg.sv
// Shared widths and saturation limits for the int8 -> int32 dequantizer.
package dequant_pkg;
  localparam int DQ_IN_W    = 8;
  localparam int DQ_OUT_W   = 32;
  localparam int DQ_SCALE_W = 16;
  localparam int DQ_P_W     = DQ_IN_W + DQ_SCALE_W;
  localparam logic [DQ_OUT_W-1:0] DQ_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DQ_OUT_W-1:0] DQ_SAT_MIN = 32'h8000_0000;
endpackage

// File: rtl/dequantize_stream_if.sv
// Stream bundle for the dequantizer: int8 beats in, int32 beats out.
interface dequantize_stream_if #(parameter int N_ELEM = 4);
  import dequant_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [N_ELEM*DQ_IN_W-1:0]    in_data;
  logic [DQ_SCALE_W-1:0]        scale;
  logic [4:0]                   shift_amount;
  logic                         out_valid;
  logic                         out_ready;
  logic [N_ELEM*DQ_OUT_W-1:0]   out_data;
  logic [N_ELEM-1:0]            out_sat;
  logic                         out_last;

  modport master (
    output in_valid, in_data, scale, shift_amount, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_last
  );

  modport slave (
    input  in_valid, in_data, scale, shift_amount, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_last
  );
endinterface

// File: rtl/dequant_lane.sv
// One element of stage 2: arithmetic left shift of the product, then clamp to int32.
module dequant_lane
  import dequant_pkg::*;
(
  input  logic signed [DQ_P_W-1:0]   p,
  input  logic [4:0]                 shift,
  output logic [DQ_OUT_W-1:0]        value,
  output logic                       sat
);
  localparam int W_W = DQ_P_W + 32;

  logic signed [W_W-1:0] w;
  logic                  over;
  logic                  under;

  assign w = $signed({{32{p[DQ_P_W-1]}}, p}) <<< shift;

  // in range only when every bit above bit 31 matches the sign bit
  assign over  = ~w[W_W-1] & (|w[W_W-2:DQ_OUT_W-1]);
  assign under =  w[W_W-1] & ~(&w[W_W-2:DQ_OUT_W-1]);

  always_comb begin
    value = w[DQ_OUT_W-1:0];
    sat   = 1'b0;
    if (over) begin
      value = DQ_SAT_MAX;
      sat   = 1'b1;
    end else if (under) begin
      value = DQ_SAT_MIN;
      sat   = 1'b1;
    end
  end
endmodule

// File: rtl/dequantize_stream.sv
// Two-stage streaming dequantizer: multiply on accept, shift+saturate into the output
// register, with tile beat counting on the output side.
module dequantize_stream
  import dequant_pkg::*;
#(
  parameter int N_ELEM     = 4,
  parameter int TILE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  dequantize_stream_if.slave bus
);
  localparam int CNT_W = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_BEATS - 1);

  logic                        s1_valid;
  logic                        s2_valid;
  logic                        s1_adv;
  logic                        s2_adv;
  logic                        in_fire;
  logic                        out_fire;
  logic signed [DQ_P_W-1:0]    prod [N_ELEM];
  logic signed [DQ_P_W-1:0]    s1_p [N_ELEM];
  logic [4:0]                  s1_shift;
  logic [N_ELEM*DQ_OUT_W-1:0]  lane_value;
  logic [N_ELEM-1:0]           lane_sat;
  logic [N_ELEM*DQ_OUT_W-1:0]  s2_data;
  logic [N_ELEM-1:0]           s2_sat;
  logic [CNT_W-1:0]            beat_cnt;

  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = s1_valid & s2_adv;
  assign bus.in_ready = ~rst & (~s1_valid | s2_adv);
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = s2_valid & bus.out_ready;

  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_lane
    logic [DQ_IN_W-1:0] x;
    assign x = bus.in_data[gi*DQ_IN_W +: DQ_IN_W];
    // both operands widened to the product width so the multiply is fully signed
    assign prod[gi] = $signed({{DQ_SCALE_W{x[DQ_IN_W-1]}}, x}) *
                      $signed({{DQ_IN_W{bus.scale[DQ_SCALE_W-1]}}, bus.scale});

    dequant_lane u_lane (
      .p     (s1_p[gi]),
      .shift (s1_shift),
      .value (lane_value[gi*DQ_OUT_W +: DQ_OUT_W]),
      .sat   (lane_sat[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_shift <= '0;
      s2_data  <= '0;
      s2_sat   <= '0;
      beat_cnt <= '0;
      for (int i = 0; i < N_ELEM; i++) s1_p[i] <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_shift <= bus.shift_amount;
        for (int i = 0; i < N_ELEM; i++) s1_p[i] <= prod[i];
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= lane_value;
        s2_sat   <= lane_sat;
      end else if (s2_adv) begin
        s2_valid <= 1'b0;
      end

      if (out_fire) beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sat   = s2_sat;
  assign bus.out_last  = s2_valid & (beat_cnt == LAST_CNT);
endmodule

// File: tb/tb_dequantize_stream.sv
// Bench for dequantize_stream: vector table plus stall, tile and reset sequences,
// all checked through an in-order scoreboard.
module tb_dequantize_stream;
  import dequant_pkg::*;

  localparam int N  = 4;
  localparam int TB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dequantize_stream_if #(.N_ELEM(N)) bus ();
  dequantize_stream #(.N_ELEM(N), .TILE_BEATS(TB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0]  in_data;
    logic [15:0]  scale;
    logic [4:0]   shift;
    logic [127:0] exp_data;
    logic [3:0]   exp_sat;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   sat;
  } exp_t;

  vec_t pend[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tb_beat = 0;
  int   n_last = 0;
  bit   rand_ready = 1'b0;
  logic         hold_valid = 1'b0;
  logic [127:0] hold_data;
  logic [3:0]   hold_sat;
  logic         hold_last;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk8(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [127:0] pk32(int a, int b, int c, int d);
    return {d, c, b, a};
  endfunction

  // reference: 64-bit integer arithmetic, then clamp
  function automatic vec_t rand_vec();
    vec_t   v;
    longint p;
    longint w;
    v.in_data = $urandom;
    v.scale   = 16'($urandom);
    v.shift   = 5'($urandom_range(0, 24));
    for (int i = 0; i < N; i++) begin
      p = longint'($signed(v.in_data[i*8 +: 8])) * longint'($signed(v.scale));
      w = p <<< v.shift;
      if (w > 64'sd2147483647) begin
        v.exp_data[i*32 +: 32] = 32'h7FFF_FFFF;
        v.exp_sat[i] = 1'b1;
      end else if (w < -64'sd2147483648) begin
        v.exp_data[i*32 +: 32] = 32'h8000_0000;
        v.exp_sat[i] = 1'b1;
      end else begin
        v.exp_data[i*32 +: 32] = w[31:0];
        v.exp_sat[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // present the head of the pending queue just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pend.size() > 0) begin
      bus.in_valid     = 1'b1;
      bus.in_data      = pend[0].in_data;
      bus.scale        = pend[0].scale;
      bus.shift_amount = pend[0].shift;
    end else begin
      bus.in_valid = 1'b0;
    end
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // handshakes are decided on the coming rising edge; inspect them half a cycle early
  always @(negedge clk) begin : mon
    exp_t e;
    vec_t v;
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data", bus.out_data, hold_data);
        check("stall_sat", bus.out_sat, hold_sat);
        check("stall_last", bus.out_last, hold_last);
      end
      hold_valid = bus.out_valid & ~bus.out_ready;
      hold_data  = bus.out_data;
      hold_sat   = bus.out_sat;
      hold_last  = bus.out_last;

      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %h with nothing outstanding", bus.out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_sat", bus.out_sat, e.sat);
          check("out_last", bus.out_last, (tb_beat % TB) == TB - 1);
          if (bus.out_last) n_last++;
          tb_beat++;
        end
      end else if (!bus.out_valid) begin
        check("idle_last", bus.out_last, 1'b0);
      end

      if (bus.in_valid && bus.in_ready && pend.size() > 0) begin
        v = pend.pop_front();
        sb.push_back('{v.exp_data, v.exp_sat});
      end
    end
  end

  task automatic drain(int limit);
    int k = 0;
    while ((pend.size() != 0 || sb.size() != 0) && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (pend.size() != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending %0d in flight after %0d cycles, required 0 and 0",
               pend.size(), sb.size(), k);
    end
  endtask

  initial begin
    vec_t tbl[9];
    int   lat;

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.scale        = '0;
    bus.shift_amount = '0;
    bus.out_ready    = 1'b1;

    tbl[0] = '{pk8(-1, 2, 127, -128), 16'd3, 5'd4, pk32(-48, 96, 6096, -6144), 4'b0000};
    tbl[1] = '{pk8(127, -128, 0, 1), 16'd32767, 5'd10,
               pk32(32'h7FFFFFFF, 32'h80000000, 0, 33553408), 4'b0011};
    tbl[2] = '{pk8(1, -1, 0, 1), 16'd1, 5'd31,
               pk32(32'h7FFFFFFF, 32'h80000000, 0, 32'h7FFFFFFF), 4'b1001};
    tbl[3] = '{pk8(-2, 2, -1, 1), 16'd1, 5'd31,
               pk32(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF), 4'b1011};
    tbl[4] = '{pk8(127, -128, 5, -5), 16'd0, 5'd31, 128'd0, 4'b0000};
    tbl[5] = '{pk8(0, 0, 0, 0), 16'h8000, 5'd31, 128'd0, 4'b0000};
    tbl[6] = '{pk8(-128, 127, -1, 1), 16'h8000, 5'd0,
               pk32(4194304, -4161536, 32768, -32768), 4'b0000};
    tbl[7] = '{pk8(-128, -128, 127, 127), 16'h8000, 5'd9,
               pk32(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h81000000, 32'h81000000), 4'b0011};
    tbl[8] = '{pk8(-128, 0, 0, 0), 16'h8000, 5'd8, pk32(32'h40000000, 0, 0, 0), 4'b0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_sat", bus.out_sat, '0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // accept-to-output latency on an empty pipe
    pend.push_back(tbl[0]);
    for (int k = 0; k < 20 && sb.size() == 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("first_accept", sb.size(), 1);
    lat = 0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 2);
    drain(50);

    // whole table back to back
    for (int i = 0; i < 9; i++) pend.push_back(tbl[i]);
    drain(100);

    // backpressure: the two stages fill, then input stalls
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pend.push_back(rand_vec());
    repeat (6) begin
      @(negedge clk);
      #1;
    end
    check("held_beats", sb.size(), 2);
    check("stall_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain(100);

    // tile marking under random downstream backpressure, from a fresh tile
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    tb_beat = 0;
    n_last  = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 9; i++) pend.push_back(rand_vec());
    drain(500);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    check("tile_last_count", n_last, 2);
    for (int i = 0; i < 3; i++) pend.push_back(rand_vec());
    drain(100);
    check("tile_resume_last", n_last, 3);

    // reset with both stages occupied
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) pend.push_back(rand_vec());
    for (int k = 0; k < 30 && sb.size() < 2; k++) begin
      @(negedge clk);
      #1;
    end
    check("full_before_rst", sb.size(), 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pend.delete();
    sb.delete();
    tb_beat = 0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_out_last", bus.out_last, 1'b0);
    check("mid_rst_out_data", bus.out_data, '0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    n_last        = 0;
    for (int i = 0; i < 4; i++) pend.push_back(rand_vec());
    drain(100);
    check("post_rst_last", n_last, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
